// File: rtl/sdram_tb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_tb_pkg
//
// Shared definitions for the SDRAM port responder and its RAM.
//   - Default word width, buffer depth and init delay.
//   - A short init delay for simulation builds.
//   - The init/ready FSM state type.
//   - A width helper for counters that must also work for tiny counts.
// -----------------------------------------------------------------------------
package sdram_tb_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int DEPTH_DEF       = 1024;
  localparam int INIT_CYCLES_DEF = 10000;  // 200 us at 50 MHz
  localparam int INIT_CYCLES_SIM = 16;     // keeps simulations short

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_t;

  // Counter width able to hold 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_resp_ram.sv
// -----------------------------------------------------------------------------
// sdram_resp_ram
//
// DEPTH x DATA_W single-clock RAM: one write port, one registered read port.
// A read and a write to the same address in the same cycle return the old
// contents (read-before-write).
//
// Ports:
//   clk_50m  in   system clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   re       in   read enable; rdata updates after the edge that samples it
//   raddr    in   read address
//   rdata    out  registered read data (holds between reads)
// -----------------------------------------------------------------------------
module sdram_resp_ram
  import sdram_tb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_50m,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the tools can map
  // them onto block RAM; validity of a location is tracked outside this module.
  always_ff @(posedge clk_50m) begin
    // NOTE: non-blocking assignments make the read below see the value held
    // before this edge's write, which is exactly read-before-write.
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sdram_port_responder.sv
// -----------------------------------------------------------------------------
// sdram_port_responder
//
// Stand-in for the SDRAM controller's user-side FIFO ports. After reset it
// spends INIT_CYCLES cycles in INIT, then sits in READY for good. In READY it
// stores a stream of write words into a circular buffer and returns read words
// in address order with one cycle of latency. Unwritten locations read as 0.
// Any access during INIT is dropped and latches the sticky proto_err flag.
//
// Optional build macro: SDRAM_RESP_FAULT_INJ_EN
//   Adds parameter FAULT_ADDR; reads of that address return the stored word
//   with bit 0 inverted (unwritten locations still return 0).
//
// Ports:
//   clk_50m          in   system clock
//   rst_n            in   asynchronous active-low reset
//   wr_en            in   write strobe, one word per cycle
//   wr_data          in   write word
//   rd_en            in   read strobe, one word per cycle
//   rd_data          out  read word, valid with rd_valid (0 otherwise)
//   rd_valid         out  rd_data valid this cycle
//   sdram_init_done  out  level, high once the FSM is in READY
//   wr_words         out  words written, saturates at DEPTH
//   proto_err        out  sticky: access attempted during INIT
// -----------------------------------------------------------------------------
module sdram_port_responder
  import sdram_tb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int INIT_CYCLES = INIT_CYCLES_DEF
`ifdef SDRAM_RESP_FAULT_INJ_EN
  ,
  parameter int FAULT_ADDR  = 100
`endif
) (
  input  logic                     clk_50m,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     sdram_init_done,
  output logic [$clog2(DEPTH):0]   wr_words,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = AW + 1;
  localparam int CW = cnt_width(INIT_CYCLES);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  init_state_t       state_q, state_d;
  logic [CW-1:0]     init_cnt_q;
  logic [AW-1:0]     wp_q, rp_q;
  logic [DEPTH-1:0]  written_q;
  logic [WW-1:0]     wr_words_q;
  logic              proto_err_q;
  logic              rd_valid_q;
  logic              rd_hit_q;     // location read last cycle had been written
  logic [DATA_W-1:0] ram_rdata;

  // Decoded controls
  logic              init_cnt_en;
  logic              wr_acc;
  logic              rd_acc;
  logic              proto_viol;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. READY is terminal; only reset leaves it.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    if (state_q == INIT && init_cnt_q == INIT_LAST) begin
      state_d = READY;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and access qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    sdram_init_done = 1'b0;
    init_cnt_en     = 1'b0;
    wr_acc          = 1'b0;
    rd_acc          = 1'b0;
    proto_viol      = 1'b0;
    case (state_q)
      INIT: begin
        init_cnt_en = 1'b1;
        proto_viol  = wr_en | rd_en;
      end
      READY: begin
        sdram_init_done = 1'b1;
        wr_acc          = wr_en;
        rd_acc          = rd_en;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Init counter. Stops at its terminal value; the FSM leaves INIT on the same
  // edge, so the counter value is irrelevant afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
    end else if (init_cnt_en && init_cnt_q != INIT_LAST) begin
      init_cnt_q <= init_cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Write side: pointer, written bitmap, saturating word count.
  // The pointer wraps by natural overflow (DEPTH is a power of two).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      written_q  <= '0;
      wr_words_q <= '0;
    end else if (wr_acc) begin
      wp_q            <= wp_q + AW'(1);
      written_q[wp_q] <= 1'b1;
      if (wr_words_q != WW'(DEPTH)) begin
        wr_words_q <= wr_words_q + WW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: pointer and response qualifiers. written_q is sampled with the
  // same edge that may set it, so a same-address write in the same cycle is
  // not seen (consistent with the RAM's read-before-write).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rp_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_hit_q   <= rd_acc & written_q[rp_q];
      if (rd_acc) begin
        rp_q <= rp_q + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if (proto_viol) begin
      proto_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sdram_resp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_50m (clk_50m),
    .we      (wr_acc),
    .waddr   (wp_q),
    .wdata   (wr_data),
    .re      (rd_acc),
    .raddr   (rp_q),
    .rdata   (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Optional fault injection: remember whether the last read hit FAULT_ADDR.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_flip;

`ifdef SDRAM_RESP_FAULT_INJ_EN
  logic rd_fault_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rd_fault_q <= 1'b0;
    end else begin
      rd_fault_q <= rd_acc && (rp_q == AW'(FAULT_ADDR));
    end
  end

  assign rd_flip = {{(DATA_W-1){1'b0}}, rd_fault_q};
`else
  assign rd_flip = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. The RAM register is unreset, so rd_data is gated by the reset
  // qualifiers: 0 after reset, when idle, and for unwritten locations.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (rd_valid_q && rd_hit_q) begin
      rd_data = ram_rdata ^ rd_flip;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign wr_words  = wr_words_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sdram_port_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_responder
//
// Directed bench for sdram_port_responder with INIT_CYCLES = 16, DEPTH = 1024.
// Each issued read pushes its hand-derived expected word into a queue; a
// monitor on the falling edge pops and compares whenever rd_valid is high.
// Level outputs (init done, word count, error flag) are checked directly.
// -----------------------------------------------------------------------------
module tb_sdram_port_responder;
  import sdram_tb_pkg::*;

  localparam int DW     = 16;
  localparam int DEPTH  = 1024;
  localparam int N_INIT = INIT_CYCLES_SIM;

  logic                  clk_50m = 1'b0;
  logic                  rst_n   = 1'b0;
  logic                  wr_en   = 1'b0;
  logic [DW-1:0]         wr_data = '0;
  logic                  rd_en   = 1'b0;
  logic [DW-1:0]         rd_data;
  logic                  rd_valid;
  logic                  sdram_init_done;
  logic [$clog2(DEPTH):0] wr_words;
  logic                  proto_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];

  sdram_port_responder #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .INIT_CYCLES (N_INIT)
  ) dut (
    .clk_50m         (clk_50m),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .sdram_init_done (sdram_init_done),
    .wr_words        (wr_words),
    .proto_err       (proto_err)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set before the call are sampled
  // at that edge, and registered outputs are settled on return.
  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  // Expected read word for a given address and stored value.
  function automatic logic [DW-1:0] rd_exp(input int addr, input logic [DW-1:0] val,
                                           input bit was_written);
    if (!was_written) return '0;
`ifdef SDRAM_RESP_FAULT_INJ_EN
    if (addr == 100) return val ^ 16'h0001;
`endif
    return val;
  endfunction

  // Issue one read this cycle (rd_en stays high afterwards).
  task automatic issue_read(input int addr, input logic [DW-1:0] val, input bit was_written);
    rd_en = 1'b1;
    exp_q.push_back(rd_exp(addr, val, was_written));
    tick();
  endtask

  task automatic reset_and_ready();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #5;
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (N_INIT) tick();
    check("ready_after_reset", sdram_init_done, 1'b1);
    check("proto_err_after_reset", proto_err, 1'b0);
    check("wr_words_after_reset", wr_words, '0);
  endtask

  // Scoreboard monitor
  always @(negedge clk_50m) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=0x%0h expected no response", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
      end
    end
  end

  initial begin
    // ---- 1: reset state and init timing --------------------------------
    #35;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_init_done", sdram_init_done, 1'b0);
    check("rst_wr_words", wr_words, '0);
    check("rst_proto_err", proto_err, 1'b0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("init_done_c%0d", k), sdram_init_done, (k >= N_INIT) ? 1'b1 : 1'b0);
    end
    check("idle_wr_words", wr_words, '0);
    check("idle_proto_err", proto_err, 1'b0);
    check("idle_rd_valid", rd_valid, 1'b0);

    // ---- 2: accesses during INIT -----------------------------------------
    rst_n = 1'b0;
    #5;
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (5) tick();                 // now in cycle 5
    check("proto_err_c5", proto_err, 1'b0);
    wr_en   = 1'b1;
    wr_data = 16'hABCD;
    tick();                            // cycle 6
    wr_en = 1'b0;
    check("proto_err_c6", proto_err, 1'b1);
    rd_en = 1'b1;                      // ignored read: no rd_valid expected
    tick();
    rd_en = 1'b0;
    tick();
    check("init_read_no_valid", rd_valid, 1'b0);
    repeat (N_INIT - 8) tick();
    check("init_done_after_err", sdram_init_done, 1'b1);
    check("proto_err_sticky", proto_err, 1'b1);
    check("wr_words_ignored", wr_words, '0);
    issue_read(0, '0, 1'b0);
    check("rd_latency_valid", rd_valid, 1'b1);
    rd_en = 1'b0;
    tick();

    // ---- 3: 1..1024 written, two full read passes ------------------------
    reset_and_ready();
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    check("wr_words_full", wr_words, DEPTH);
    for (int j = 0; j < 2 * DEPTH; j++) begin
      issue_read(j % DEPTH, DW'((j % DEPTH) + 1), 1'b1);
      if (j == 2 * DEPTH - 1) check("rd_valid_last", rd_valid, 1'b1);
    end
    rd_en = 1'b0;
    tick();
    check("rd_valid_fall", rd_valid, 1'b0);

    // ---- 4: 1..1100 written, saturation and overwrite --------------------
    reset_and_ready();
    for (int i = 1; i <= 1100; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    check("wr_words_sat", wr_words, DEPTH);
    for (int j = 0; j < DEPTH; j++) begin
      issue_read(j, (j < 76) ? DW'(1025 + j) : DW'(j + 1), 1'b1);
    end
    rd_en = 1'b0;
    tick();

    // ---- 5: read-before-write at wp == rp --------------------------------
    reset_and_ready();
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(16'h1110 + i);
      issue_read(i, '0, 1'b0);         // same address, old (unwritten) contents
    end
    wr_en = 1'b0;
    for (int j = 6; j < DEPTH; j++) issue_read(j, '0, 1'b0);
    for (int j = 0; j < 6; j++) issue_read(j, DW'(16'h1110 + j), 1'b1);
    rd_en = 1'b0;
    tick();
    check("wr_words_rbw", wr_words, 6);

    // ---- 6: reset asserted mid-read --------------------------------------
    reset_and_ready();
    wr_en   = 1'b1;
    wr_data = 16'h0055;
    tick();
    wr_data = 16'h0066;
    tick();
    wr_en = 1'b0;
    issue_read(0, 16'h0055, 1'b1);
    issue_read(1, 16'h0066, 1'b1);     // rd_en still high
    @(negedge clk_50m);
    #1;
    check("midread_valid_before", rd_valid, 1'b1);
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    check("midread_valid_async", rd_valid, 1'b0);
    check("midread_done_async", sdram_init_done, 1'b0);
    check("midread_rd_data", rd_data, '0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    for (int k = 1; k <= N_INIT; k++) begin
      tick();
      if (k >= N_INIT - 1)
        check($sformatf("reinit_done_c%0d", k), sdram_init_done, (k >= N_INIT) ? 1'b1 : 1'b0);
    end
    wr_en   = 1'b1;
    wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    issue_read(0, 16'hBEEF, 1'b1);     // rp back at 0, data written last cycle
    rd_en = 1'b0;
    repeat (3) tick();

    check("outstanding_reads", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_port_responder.md
# sdram_port_responder

Synthesizable stand-in for the SDRAM controller's user-side FIFO ports, driven by the SDRAM read/write traffic generator in `sdram_tb`. It models power-up initialisation and accepts a stream of write words into a circular buffer. It returns read words in the same address order with fixed one-cycle latency, so the self-checking loop can run on-board or in simulation without the physical SDRAM or the full controller.

## Interface
Parameters:
- DATA_W, 16, word width
- DEPTH, 1024, buffer words; power of two
- INIT_CYCLES, 10000, clk_50m cycles from reset release to init done (200 us)

Ports:
- clk_50m  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- wr_en  input  1  write strobe, one word per cycle
- wr_data  input  DATA_W  write word
- rd_en  input  1  read strobe, one word per cycle
- rd_data  output  DATA_W  read word
- rd_valid  output  1  rd_data valid this cycle
- sdram_init_done  output  1  initialisation complete, level
- wr_words  output  $clog2(DEPTH)+1  words written, saturates at DEPTH
- proto_err  output  1  sticky protocol violation

## Operation
- FSM states: INIT and READY.
  - INIT: reset state. An init counter increments every cycle. When the counter equals INIT_CYCLES-1, the FSM moves to READY.
  - READY: terminal state. Only reset leaves it.
- sdram_init_done = 1 exactly when the FSM is in READY.
- Write pointer wp and read pointer rp are $clog2(DEPTH) bits. Both wrap modulo DEPTH; wrap is natural overflow.
- Write, in READY with wr_en=1:
  - mem[wp] <= wr_data.
  - written[wp] <= 1.
  - wp increments.
  - wr_words increments unless it already equals DEPTH.
- Read, in READY with rd_en=1:
  - Next cycle, rd_data = mem[rp] if written[rp] is set, else 0.
  - rd_valid = 1 in that cycle.
  - rp increments.
- Reads do not consume data. Rereading the region after rp wraps returns the same words.
- Simultaneous wr_en and rd_en with wp==rp: read-before-write. The read returns the old contents, or 0 if the location was unwritten.
- Any wr_en or rd_en while in INIT:
  - The access is ignored; no pointer moves and no data is stored.
  - proto_err <= 1.
  - The ignored read produces no rd_valid pulse.
- proto_err clears only on reset.
- Reset values:
  - rd_data=0, rd_valid=0, sdram_init_done=0, wr_words=0, proto_err=0.
  - wp=0, rp=0, all written bits=0, FSM=INIT, init counter=0.
  - mem contents are not reset.
- Reset asserted mid-operation: all of the above return to reset values immediately (asynchronous). The init delay restarts in full after rst_n deasserts.

## Timing
- sdram_init_done rises on the clock edge ending cycle INIT_CYCLES after rst_n deasserts. It is registered.
- Read latency is 1 cycle: rd_en sampled high at edge N gives rd_data/rd_valid valid after edge N+1.
- With continuous rd_en, throughput is one word per cycle. rd_valid falls one cycle after rd_en falls.
- Write throughput is one word per cycle. Written data is readable by a read issued in the following cycle.
- wr_words updates one cycle after the accepted write.

## Configuration
- SDRAM_RESP_FAULT_INJ_EN
  - Defined: add parameter FAULT_ADDR (default 100). Every read of address FAULT_ADDR returns the stored word with bit 0 inverted, and only if that location was written; an unwritten location still returns 0. This lets the checker's error flag be exercised.
  - Undefined: no fault logic, and FAULT_ADDR is absent.

## Structure
- Package `sdram_tb_pkg` holds:
  - DATA_W and DEPTH defaults.
  - INIT_CYCLES default, plus a simulation-short value of 16.
  - The FSM state typedef (INIT, READY).
- Sub-module `sdram_resp_ram`: DEPTH×DATA_W single-clock RAM with one write port and one registered read port, read-before-write. The written bitmap and FSM stay in the top.

## Test plan
Use INIT_CYCLES=16 unless stated otherwise.
- Reset release, no traffic -> sdram_init_done=0 through cycle 15, 1 from cycle 16; all other outputs stay 0.
- wr_en pulsed at cycle 5 (in INIT) -> proto_err=1 from cycle 6; wr_words stays 0; after READY, a read of address 0 returns 0.
- Write 1..1024 continuously, then hold rd_en for 2048 cycles -> rd_data sequence 1..1024 twice; rd_valid continuous; wr_words=1024.
- Write 1..1100 -> wr_words saturates at 1024; addresses 0..75 hold 1025..1100; a full read pass returns 1025..1100, then 77..1024.
- Write 5 words (wp=5) while rd_en issued at rp=5 in the same cycle -> read returns 0 (unwritten); a reread after wrap returns the written value.
- With SDRAM_RESP_FAULT_INJ_EN and FAULT_ADDR=100, write 1..1024 then read -> the word at address 100 returns 100 (101 with bit 0 flipped); all other words are correct. Without the macro, 101 is returned.
- Assert rst_n low mid-read -> rd_valid=0 and sdram_init_done=0 immediately; after release, READY is reached again 16 cycles later and rp restarts at 0.
